// File: rtl/lector_solicitudes_if.sv
// Handshake and serial-chain bundle for the floor-request reader.
// slave = reader side, master = controller/chain side.
interface lector_solicitudes_if #(
  parameter int N_PISOS = 5,
  parameter int PISO_W  = 3
);
  logic                   start;
  logic [PISO_W-1:0]      piso_actual;
  logic                   borrar_en;
  logic [PISO_W-1:0]      piso_borrar;
  logic                   serial_in;
  logic                   serial_out;
  logic                   shift_en;
  logic                   busy;
  logic                   done;
  logic                   pedido_valido;
  logic [PISO_W-1:0]      piso_destino;
  logic                   subiendo;
  logic [2*N_PISOS-1:0]   snapshot;

  modport slave (
    input  start, piso_actual, borrar_en,
    input  piso_borrar, serial_in,
    output serial_out, shift_en, busy, done,
    output pedido_valido, piso_destino,
    output subiendo, snapshot
  );

  modport master (
    output start, piso_actual, borrar_en,
    output piso_borrar, serial_in,
    input  serial_out, shift_en, busy, done,
    input  pedido_valido, piso_destino,
    input  subiendo, snapshot
  );
endinterface

// File: rtl/lector_solicitudes.sv
// Floor-request chain reader: rotates the chain once,
// optionally clears one floor, then picks the next target.
module lector_solicitudes #(
  parameter int N_PISOS = 5,
  parameter int PISO_W  = 3
) (
  input  logic clk,
  input  logic reset_n,
  lector_solicitudes_if.slave bus
);
  localparam int W  = 2 * N_PISOS;
  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE, SHIFT, DECIDE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [W-1:0]      cap_q;
  logic [W-1:0]      snap_q;
  logic [PISO_W-1:0] dest_q, dest_d;
  logic              sub_q, sub_d;
  logic              valid_q, valid_d;
  logic [PISO_W-1:0] act_q;
  logic              ben_q;
  logic [PISO_W-1:0] pb_q;

  logic              accept;
  logic              shift_en;
  logic              busy;
  logic              done;
  logic              clr_hit;
  logic              ser_o;
  logic [N_PISOS-1:0] req;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs; DONE may
  // accept a new start so scans can run back-to-back
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        if (k_q == '0) state_d = DECIDE;
      end
      DECIDE: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero the bit pair of the floor being cleared as it recirculates
  always_comb begin
    clr_hit = 1'b0;
    if (state_q == SHIFT && ben_q)
      clr_hit = ((32'(k_q) >> 1) == 32'(pb_q));
    ser_o = clr_hit ? 1'b0 : bus.serial_in;
  end

  // Per-floor request flags from the captured chain
  always_comb begin
    req = '0;
    for (int f = 0; f < N_PISOS; f++)
      req[f] = cap_q[2*f] | cap_q[2*f+1];
  end

  // Target selection: current floor first, then
  // continue in the travel direction, else reverse
  always_comb begin
    int                act_n;
    logic              here, up_hit, dn_hit;
    logic [PISO_W-1:0] up_fl, dn_fl;
    dest_d  = dest_q;
    sub_d   = sub_q;
    valid_d = valid_q;
    act_n   = int'(act_q);
    here    = 1'b0;
    up_hit  = 1'b0;
    dn_hit  = 1'b0;
    up_fl   = '0;
    dn_fl   = '0;
    for (int f = N_PISOS - 1; f >= 0; f--) begin
      if (req[f] && f > act_n) begin
        up_hit = 1'b1;
        up_fl  = PISO_W'(f);
      end
    end
    for (int f = 0; f < N_PISOS; f++) begin
      if (req[f] && f < act_n) begin
        dn_hit = 1'b1;
        dn_fl  = PISO_W'(f);
      end
      if (req[f] && f == act_n) here = 1'b1;
    end
    if (act_n >= N_PISOS) begin
      valid_d = 1'b0;
    end else if (here) begin
      dest_d  = act_q;
      valid_d = 1'b1;
    end else if (sub_q) begin
      if (up_hit) begin
        dest_d  = up_fl;
        valid_d = 1'b1;
      end else if (dn_hit) begin
        dest_d  = dn_fl;
        sub_d   = 1'b0;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      if (dn_hit) begin
        dest_d  = dn_fl;
        valid_d = 1'b1;
      end else if (up_hit) begin
        dest_d  = up_fl;
        sub_d   = 1'b1;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Latch scan parameters, shift capture, commit decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q     <= '0;
      cap_q   <= '0;
      snap_q  <= '0;
      dest_q  <= '0;
      sub_q   <= 1'b1;
      valid_q <= 1'b0;
      act_q   <= '0;
      ben_q   <= 1'b0;
      pb_q    <= '0;
    end else begin
      if (accept) begin
        act_q <= bus.piso_actual;
        ben_q <= bus.borrar_en;
        pb_q  <= bus.piso_borrar;
        k_q   <= KW'(W - 1);
      end
      if (state_q == SHIFT) begin
        cap_q <= {cap_q[W-2:0], ser_o};
        if (k_q != '0) k_q <= k_q - 1'b1;
      end
      if (state_q == DECIDE) begin
        snap_q  <= cap_q;
        dest_q  <= dest_d;
        sub_q   <= sub_d;
        valid_q <= valid_d;
      end
    end
  end

  assign bus.serial_out    = ser_o;
  assign bus.shift_en      = shift_en;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pedido_valido = valid_q;
  assign bus.piso_destino  = dest_q;
  assign bus.subiendo      = sub_q;
  assign bus.snapshot      = snap_q;
endmodule
